int2flt_seq: RTL and testbench

//  Multi-cycle converter from 16-bit two's-complement integer to IEEE-754 half precision (1/5/10, bias 15).

---
 rtl/int2flt_seq.sv | 106 ++++++++++
 tb/tb_int2flt_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/int2flt_seq.sv
// int2flt_seq: sequential int16 -> IEEE-754 half converter that reads its operand from and writes its result to data memory
// Ports:
//   clk        clock, all state updates on posedge
//   reset      synchronous, active-high; aborts any conversion in flight
//   start      request; a conversion is triggered by its falling edge while idle
//   done       one-cycle pulse once both result bytes have been written
//   mem_addr   data memory address (registered, holds its last value when unused)
//   mem_rd_en  read enable for the two operand bytes
//   mem_wr_en  write enable, one result byte per cycle
//   mem_wdata  write data (registered, holds its last value when unused)
//   mem_rdata  combinational read data for mem_addr, captured at the end of each read cycle
module int2flt_seq #(
  parameter logic [7:0] SRC_ADDR = 8'd0,
  parameter logic [7:0] DST_ADDR = 8'd2,
  parameter logic       ROUND    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);
  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] RD_LO = 4'd1;
  localparam logic [3:0] RD_HI = 4'd2;
  localparam logic [3:0] PREP  = 4'd3;
  localparam logic [3:0] NORM  = 4'd4;
  localparam logic [3:0] RND   = 4'd5;
  localparam logic [3:0] WR_LO = 4'd6;
  localparam logic [3:0] WR_HI = 4'd7;
  localparam logic [3:0] ACK   = 4'd8;
  logic [3:0]  r_state, w_nxt;
  logic        r_start_q, r_sign;
  logic [15:0] r_x, r_mag, r_res;
  logic [3:0]  r_e;
  logic        w_inc;
  logic [10:0] w_msum;
  logic [4:0]  w_bexp;
  logic [15:0] w_res;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = (r_start_q && !start) ? RD_LO : IDLE;
      RD_LO:   w_nxt = RD_HI;
      RD_HI:   w_nxt = PREP;
      PREP:    w_nxt = (r_x == 16'h0000) ? WR_LO : NORM;
      NORM:    w_nxt = r_mag[15] ? RND : NORM;
      RND:     w_nxt = WR_LO;
      WR_LO:   w_nxt = WR_HI;
      WR_HI:   w_nxt = ACK;
      default: w_nxt = IDLE;
    endcase
  end
  // Round to nearest even on the bits below the 10-bit mantissa; a mantissa
  // carry-out bumps the exponent and leaves an all-zero mantissa.
  assign w_inc  = ROUND & r_mag[4] & ((|r_mag[3:0]) | r_mag[5]);
  assign w_msum = {1'b0, r_mag[14:5]} + {10'd0, w_inc};
  assign w_bexp = {1'b0, r_e} + 5'd15 + {4'd0, w_msum[10]};
  // Only RND and PREP (zero operand) lead into WR_LO; zero yields +0.
  assign w_res  = (r_state == RND) ? {r_sign, w_bexp, w_msum[10] ? 10'd0 : w_msum[9:0]} : 16'h0000;
  // Memory outputs are registered from the next state so they are valid
  // throughout the cycle of the state that uses them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= 8'd0;
      mem_wdata <= 8'd0;
    end else begin
      r_state   <= w_nxt;
      r_start_q <= start;
      done      <= w_nxt == ACK;
      mem_rd_en <= w_nxt == RD_LO || w_nxt == RD_HI;
      mem_wr_en <= w_nxt == WR_LO || w_nxt == WR_HI;
      if (w_nxt == RD_LO) mem_addr <= SRC_ADDR;
      if (w_nxt == RD_HI) mem_addr <= SRC_ADDR + 8'd1;
      if (w_nxt == WR_LO) begin
        mem_addr  <= DST_ADDR;
        mem_wdata <= w_res[7:0];
        r_res     <= w_res;
      end
      if (w_nxt == WR_HI) begin
        mem_addr  <= DST_ADDR + 8'd1;
        mem_wdata <= r_res[15:8];
      end
      if (r_state == RD_LO) r_x[7:0] <= mem_rdata;
      if (r_state == RD_HI) r_x[15:8] <= mem_rdata;
      if (r_state == PREP) begin
        r_sign <= r_x[15];
        r_mag  <= r_x[15] ? -r_x : r_x;
        r_e    <= 4'd15;
      end
      if (r_state == NORM && !r_mag[15]) begin
        r_mag <= r_mag << 1;
        r_e   <= r_e - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_int2flt_seq.sv
// tb_int2flt_seq: scoreboard bench for int2flt_seq, rounding and truncating instances side by side
module tb_int2flt_seq;
  localparam logic [7:0] SRC = 8'd0;
  localparam logic [7:0] DST = 8'd2;
  localparam logic [15:0] DX [7] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h0803, 16'h0801};
  localparam logic [15:0] DR [7] = '{16'h3C00, 16'hBC00, 16'h0000, 16'hF800, 16'h7800, 16'h6802, 16'h6800};
  localparam logic [15:0] DT [7] = '{16'h3C00, 16'hBC00, 16'h0000, 16'hF800, 16'h77FF, 16'h6801, 16'h6800};
  typedef struct {
    logic [15:0] v;
    int t0;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [15:0] x = 16'h0000;
  logic [1:0] done, rd, wr;
  logic [7:0] addr [2];
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];
  logic [7:0] dlo [2];
  logic [7:0] dhi [2];
  int wcnt [2];
  int wlast [2];
  int badw [2];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int2flt_seq #(.SRC_ADDR(SRC), .DST_ADDR(DST), .ROUND(1'b1)) u_rn (
    .clk(clk), .reset(reset), .start(start), .done(done[0]), .mem_addr(addr[0]),
    .mem_rd_en(rd[0]), .mem_wr_en(wr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]));
  int2flt_seq #(.SRC_ADDR(SRC), .DST_ADDR(DST), .ROUND(1'b0)) u_tr (
    .clk(clk), .reset(reset), .start(start), .done(done[1]), .mem_addr(addr[1]),
    .mem_rd_en(rd[1]), .mem_wr_en(wr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]));

  always_comb
    for (int i = 0; i < 2; i++)
      rdata[i] = (addr[i] == SRC) ? x[7:0] : (addr[i] == SRC + 8'd1) ? x[15:8] : 8'h00;

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (wr[i]) begin
        wcnt[i] <= wcnt[i] + 1;
        if (addr[i] == DST) dlo[i] <= wdata[i];
        else if (addr[i] == DST + 8'd1) dhi[i] <= wdata[i];
        else badw[i] <= badw[i] + 1;
      end

  // Reference: normalise |x| into [1,2) as an exact ratio, round the 10-bit fraction.
  function automatic logic [15:0] ref_f(input logic [15:0] v, input bit rnd);
    int a, p, q, r, den;
    bit s;
    s = v[15];
    a = s ? 65536 - int'(v) : int'(v);
    if (a == 0) return 16'h0000;
    p = 0;
    while ((1 << (p + 1)) <= a) p++;
    den = 1 << p;
    q = (a * 1024) / den;
    r = (a * 1024) % den;
    if (rnd && (2 * r > den || (2 * r == den && q % 2 == 1))) q++;
    if (q == 2048) begin
      q = 1024;
      p++;
    end
    return {s, 5'(p + 15), 10'(q - 1024)};
  endfunction

  function automatic int ref_lat(input logic [15:0] v);
    int a, p;
    a = v[15] ? 65536 - int'(v) : int'(v);
    if (a == 0) return 6;
    p = 0;
    while ((1 << (p + 1)) <= a) p++;
    return 23 - p;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++)
      if (done[i]) begin
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done dut%0d: got done=1 want no done (cycle %0d)", i, cyc);
        end else begin
          if (i == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk($sformatf("result dut%0d", i), int'({dhi[i], dlo[i]}), int'(e.v));
          chk($sformatf("latency dut%0d", i), cyc - e.t0, e.lat);
          chk($sformatf("writes dut%0d", i), wcnt[i] - wlast[i], 2);
          chk($sformatf("stray_writes dut%0d", i), badw[i], 0);
        end
        wlast[i] = wcnt[i];
      end
  end

  task automatic trigger(input logic [15:0] v);
    @(posedge clk);
    #1 x = v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic convert(input logic [15:0] v, input logic [15:0] e1, input logic [15:0] e0);
    trigger(v);
    q0.push_back(exp_t'{e1, cyc, ref_lat(v)});
    q1.push_back(exp_t'{e0, cyc, ref_lat(v)});
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (q0.size() + q1.size()) > 0; k++) @(negedge clk);
    @(negedge clk);
    if ((q0.size() + q1.size()) > 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d pending want 0", q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int snap [2];
    logic [15:0] v;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_outputs dut%0d", i), int'({done[i], rd[i], wr[i], addr[i], wdata[i]}), 0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      convert(DX[i], DR[i], DT[i]);
      drain();
    end
    // Second falling edge of start lands while both instances are in NORM.
    convert(16'h0001, 16'h3C00, 16'h3C00);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drain();
    repeat (30) @(posedge clk);
    // Reset while normalising: no writes and no done may follow.
    for (int i = 0; i < 2; i++) snap[i] = wcnt[i];
    trigger(16'h0001);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(posedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("abort_writes dut%0d", i), wcnt[i], snap[i]);
    convert(16'h0803, 16'h6802, 16'h6801);
    drain();
    for (int n = 0; n < 60; n++) begin
      v = 16'($urandom());
      v = v >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) v = -v;
      convert(v, ref_f(v, 1'b1), ref_f(v, 1'b0));
      drain();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
